anabellek_hakemi: RTL

ANABELLEK_HAKEMI -- requirements
Module: anabellek_hakemi

---
 rtl/anabellek_hakemi_pkg.sv | 21 ++
 rtl/anabellek_hakemi.sv | 121 ++++++++++++
 2 files changed

// File: rtl/anabellek_hakemi_pkg.sv
// Shared definitions for the main-memory arbiter: bus widths, line geometry
// and the arbiter state encoding.
package anabellek_hakemi_pkg;

  localparam int ADRES_W      = 32;
  localparam int VERI_W       = 32;
  localparam int SATIR_KELIME = 4;
  localparam int KELIME_W     = $clog2(SATIR_KELIME);
  // Byte offset of a line: word index plus the two byte-select bits.
  localparam int OFFSET_W     = KELIME_W + 2;

  localparam logic [KELIME_W-1:0] SON_KELIME = KELIME_W'(SATIR_KELIME - 1);

  typedef enum logic [1:0] {
    BOSTA  = 2'd0,
    BO_OKU = 2'd1,
    VO_OKU = 2'd2,
    VO_YAZ = 2'd3
  } durum_t;

endpackage

// File: rtl/anabellek_hakemi.sv
// Main-memory arbiter between the instruction cache (line fills) and the data
// cache (line fills and write-backs). One 4-word burst at a time, round-robin
// on simultaneous requests, word-by-word handshake with main memory.
module anabellek_hakemi
  import anabellek_hakemi_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  // instruction cache
  input  logic                bo_istek_i,
  input  logic [ADRES_W-1:0]  bo_adres_i,
  output logic [VERI_W-1:0]   bo_veri_o,
  output logic                bo_gecerli_o,
  output logic                bo_son_o,
  // data cache
  input  logic                vo_istek_i,
  input  logic                vo_yaz_i,
  input  logic [ADRES_W-1:0]  vo_adres_i,
  input  logic [VERI_W-1:0]   vo_yaz_veri_i,
  output logic [KELIME_W-1:0] vo_kelime_o,
  output logic [VERI_W-1:0]   vo_veri_o,
  output logic                vo_gecerli_o,
  output logic                vo_son_o,
  // main memory
  output logic                bellek_istek_o,
  output logic                bellek_yaz_o,
  output logic [ADRES_W-1:0]  bellek_adres_o,
  output logic [VERI_W-1:0]   bellek_yaz_veri_o,
  input  logic                bellek_hazir_i,
  input  logic [VERI_W-1:0]   bellek_veri_i,
  output logic                mesgul_o
);

  durum_t                     r_durum, w_durum_next;
  logic [KELIME_W-1:0]        r_sayac, w_sayac_next;
  logic [ADRES_W-1:OFFSET_W]  r_satir, w_satir_next;
  // 1 = data cache was served last, so the instruction cache wins a tie.
  logic                       r_son_hakem_vo, w_son_hakem_next;

  logic                       w_bo_sec;
  logic                       w_vo_sec;
  logic                       w_son_kelime;
  logic                       w_vo_aktif;

  // Requesters supply full addresses; the in-line offset is regenerated here.
  logic                       w_unused_adres;
  assign w_unused_adres = ^{bo_adres_i[OFFSET_W-1:0], vo_adres_i[OFFSET_W-1:0]};

  // State, word counter, latched line address and round-robin flag.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_durum        <= BOSTA;
      r_sayac        <= '0;
      r_satir        <= '0;
      r_son_hakem_vo <= 1'b1;
    end else begin
      r_durum        <= w_durum_next;
      r_sayac        <= w_sayac_next;
      r_satir        <= w_satir_next;
      r_son_hakem_vo <= w_son_hakem_next;
    end
  end

  // Arbitration, burst sequencing and memory/cache handshake outputs.
  always_comb begin
    w_durum_next     = r_durum;
    w_sayac_next     = r_sayac;
    w_satir_next     = r_satir;
    w_son_hakem_next = r_son_hakem_vo;
    w_bo_sec         = 1'b0;
    w_vo_sec         = 1'b0;
    w_son_kelime     = 1'b0;

    case (r_durum)
      BOSTA: begin
        // Memory strobes arriving while idle belong to no burst and are dropped.
        w_bo_sec = bo_istek_i && (!vo_istek_i || r_son_hakem_vo);
        w_vo_sec = vo_istek_i && !w_bo_sec;
        if (w_bo_sec) begin
          w_durum_next     = BO_OKU;
          w_satir_next     = bo_adres_i[ADRES_W-1:OFFSET_W];
          w_sayac_next     = '0;
          w_son_hakem_next = 1'b0;
        end else if (w_vo_sec) begin
          w_durum_next     = vo_yaz_i ? VO_YAZ : VO_OKU;
          w_satir_next     = vo_adres_i[ADRES_W-1:OFFSET_W];
          w_sayac_next     = '0;
          w_son_hakem_next = 1'b1;
        end
      end
      default: begin
        // Once granted, the burst runs to its last word regardless of the request.
        if (bellek_hazir_i) begin
          w_sayac_next = r_sayac + KELIME_W'(1);
          if (r_sayac == SON_KELIME) begin
            w_son_kelime = 1'b1;
            w_durum_next = BOSTA;
          end
        end
      end
    endcase

    w_vo_aktif     = (r_durum == VO_OKU) || (r_durum == VO_YAZ);

    mesgul_o       = (r_durum != BOSTA);
    bellek_istek_o = (r_durum != BOSTA);
    bellek_yaz_o   = (r_durum == VO_YAZ);
    bellek_adres_o = {r_satir, r_sayac, 2'b00};
    bo_gecerli_o   = (r_durum == BO_OKU) && bellek_hazir_i;
    vo_gecerli_o   = (r_durum == VO_OKU) && bellek_hazir_i;
    bo_son_o       = w_son_kelime && (r_durum == BO_OKU);
    vo_son_o       = w_son_kelime && w_vo_aktif;
    vo_kelime_o    = w_vo_aktif ? r_sayac : '0;
  end

  // Data paths are pure pass-through, held at zero while reset is applied.
  assign bo_veri_o         = rst_i ? bellek_veri_i : '0;
  assign vo_veri_o         = rst_i ? bellek_veri_i : '0;
  assign bellek_yaz_veri_o = rst_i ? vo_yaz_veri_i : '0;

endmodule
